// File: rtl/dds_rom_seq.sv
// dds_rom_seq: phase-accumulator sequencer driving the sine ROM address port
// for the AD9708 DAC path, with phase-continuous reconfiguration and drain.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, stop           pulses: begin generation / finish period then idle
//   cfg_valid, cfg_ready  handshake for cfg_fword (tuning word) and cfg_poff
//   rom_addr, rom_data    ROM address (registered) and ROM read data
//   dac_data, dac_valid   registered DAC sample and its valid flag
//   wrap_pulse            one-cycle pulse after the accumulator carries out
//   busy                  generating or samples still in flight
module dds_rom_seq #(
    parameter int PHASE_W = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ROM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] MIDSCALE = 8'h80,
    parameter logic [PHASE_W-1:0] FWORD_RST = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PHASE_W-1:0]    cfg_fword,
    input  logic [ADDR_WIDTH-1:0] cfg_poff,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid,
    output logic                  wrap_pulse,
    output logic                  busy
);

    // FLUSH: address issue has stopped, waiting for in-flight samples.
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [PHASE_W-1:0]    acc;
    logic [PHASE_W-1:0]    fword;
    logic [ADDR_WIDTH-1:0] poff;
    logic [PHASE_W-1:0]    sh_fword;
    logic [ADDR_WIDTH-1:0] sh_poff;
    logic                  pending;
    logic [ROM_LATENCY:0]  pipe;

    logic [PHASE_W-1:0]    phase_cur;
    logic [PHASE_W:0]      sum;
    logic                  carry;
    logic                  issue;
    logic                  accept;
    logic                  idle_like;

    // The start edge issues phase 0 directly, so the first RUN cycle
    // already presents poff on rom_addr.
    assign phase_cur = (state == S_IDLE) ? '0 : acc;
    assign sum       = {1'b0, phase_cur} + {1'b0, fword};
    assign carry     = sum[PHASE_W];
    assign accept    = cfg_valid & cfg_ready;
    assign idle_like = (state == S_IDLE) || (state == S_FLUSH);

    assign cfg_ready = ~pending;
    assign busy      = (state != S_IDLE) | (|pipe) | dac_valid;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    issue     = 1'b1;
                end
            end
            S_RUN: begin
                issue = 1'b1;
                // A stop landing on the carry edge has already finished
                // its period: nothing more to drain.
                if (stop) begin
                    state_nxt = carry ? S_FLUSH : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fword == '0) begin
                    state_nxt = S_FLUSH;
                end else begin
                    issue = 1'b1;
                    if (carry) begin
                        state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (pipe == '0) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            fword      <= FWORD_RST;
            poff       <= '0;
            sh_fword   <= '0;
            sh_poff    <= '0;
            pending    <= 1'b0;
            pipe       <= '0;
            rom_addr   <= '0;
            dac_data   <= MIDSCALE;
            dac_valid  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state <= state_nxt;

            if (issue) begin
                acc      <= sum[PHASE_W-1:0];
                rom_addr <= phase_cur[PHASE_W-1 -: ADDR_WIDTH] + poff;
            end
            wrap_pulse <= issue & carry;

            pipe      <= {pipe[ROM_LATENCY-1:0], issue};
            dac_valid <= pipe[ROM_LATENCY];
            dac_data  <= pipe[ROM_LATENCY] ? rom_data : MIDSCALE;

            // Shadow config lands on the carry edge; outside generation
            // there is no carry to wait for, so it lands at once.
            if (pending && (idle_like || (issue && carry))) begin
                fword   <= sh_fword;
                poff    <= sh_poff;
                pending <= 1'b0;
            end else if (accept) begin
                if (idle_like) begin
                    fword <= cfg_fword;
                    poff  <= cfg_poff;
                end else begin
                    sh_fword <= cfg_fword;
                    sh_poff  <= cfg_poff;
                    pending  <= 1'b1;
                end
            end
        end
    end

endmodule
